// File: rtl/alu_issue_stage.sv
// ID/EX issue stage: decodes ALU op and operands and registers them behind a 2-entry skid buffer.
// Define ALU_ISSUE_FWD_EN to enable writeback-to-operand forwarding at capture time.
module alu_issue_stage #(
    parameter int WIDTH     = 32,
    parameter int IMM_WIDTH = 16,
    parameter int IDX_W     = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           in_aluop,
    input  logic [5:0]           in_funct,
    input  logic                 in_use_imm,
    input  logic [IMM_WIDTH-1:0] in_imm,
    input  logic [IDX_W-1:0]     in_rs_idx,
    input  logic [IDX_W-1:0]     in_rt_idx,
    input  logic [WIDTH-1:0]     in_rs_val,
    input  logic [WIDTH-1:0]     in_rt_val,
    input  logic                 fwd_valid,
    input  logic [IDX_W-1:0]     fwd_idx,
    input  logic [WIDTH-1:0]     fwd_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_a,
    output logic [WIDTH-1:0]     out_b,
    output logic [2:0]           out_op,
    output logic                 out_illegal
);

    localparam int EW = 2 * WIDTH + 4;
    // Entry packing: {illegal, op, b, a}
    localparam logic [EW-1:0] RST_ENTRY = {1'b0, 3'b010, {(2 * WIDTH){1'b0}}};

    logic [2:0]       dec_op;
    logic             dec_ill;
    logic [WIDTH-1:0] rs_src;
    logic [WIDTH-1:0] rt_src;
    logic [WIDTH-1:0] b_val;
    logic [EW-1:0]    dec_entry;
    logic             accept;

    logic [EW-1:0] out_q, out_d;
    logic          out_valid_q, out_valid_d;
    logic [EW-1:0] skid_q, skid_d;
    logic          skid_valid_q, skid_valid_d;
    logic          in_ready_q, in_ready_d;

    always_comb begin
        dec_op  = 3'b010;
        dec_ill = 1'b0;
        case (in_aluop)
            2'b00: dec_op = 3'b010;
            2'b01: dec_op = 3'b110;
            2'b10: begin
                case (in_funct)
                    6'b100000: dec_op = 3'b010;
                    6'b100010: dec_op = 3'b110;
                    6'b100100: dec_op = 3'b000;
                    6'b100101: dec_op = 3'b001;
                    6'b101010: dec_op = 3'b111;
                    default:   dec_ill = 1'b1;
                endcase
            end
            default: dec_ill = 1'b1;
        endcase
    end

`ifdef ALU_ISSUE_FWD_EN
    always_comb begin
        rs_src = in_rs_val;
        rt_src = in_rt_val;
        // Register 0 is hardwired, so a write to it must never be forwarded
        if (fwd_valid && (fwd_idx != '0)) begin
            if (fwd_idx == in_rs_idx)
                rs_src = fwd_data;
            if ((fwd_idx == in_rt_idx) && !in_use_imm)
                rt_src = fwd_data;
        end
    end
`else
    logic unused_fwd;
    assign unused_fwd = ^{fwd_valid, fwd_idx, fwd_data, in_rs_idx, in_rt_idx};
    assign rs_src = in_rs_val;
    assign rt_src = in_rt_val;
`endif

    assign b_val     = in_use_imm ? {{(WIDTH - IMM_WIDTH){in_imm[IMM_WIDTH-1]}}, in_imm} : rt_src;
    assign dec_entry = {dec_ill, dec_op, b_val, rs_src};
    assign accept    = in_valid && in_ready_q && !flush;

    // Output register refills from skid first so order is preserved; in_ready tracks skid occupancy
    always_comb begin
        out_d        = out_q;
        out_valid_d  = out_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!out_valid_q || out_ready) begin
            if (skid_valid_q) begin
                out_d        = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                out_d       = dec_entry;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_d       = dec_entry;
            skid_valid_d = 1'b1;
        end
        in_ready_d = !skid_valid_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q        <= RST_ENTRY;
            out_valid_q  <= 1'b0;
            skid_q       <= '0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
        end else begin
            out_q        <= out_d;
            out_valid_q  <= out_valid_d;
            skid_q       <= skid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign out_a       = out_q[WIDTH-1:0];
    assign out_b       = out_q[2*WIDTH-1:WIDTH];
    assign out_op      = out_q[2*WIDTH+2:2*WIDTH];
    assign out_illegal = out_q[2*WIDTH+3];

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: issued instructions queue their expected ALU inputs,
// a negedge monitor pops and compares on every output transfer.
module tb_alu_issue_stage;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_aluop;
    logic [5:0]  in_funct;
    logic        in_use_imm;
    logic [15:0] in_imm;
    logic [4:0]  in_rs_idx;
    logic [4:0]  in_rt_idx;
    logic [31:0] in_rs_val;
    logic [31:0] in_rt_val;
    logic        fwd_valid;
    logic [4:0]  fwd_idx;
    logic [31:0] fwd_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_a;
    logic [31:0] out_b;
    logic [2:0]  out_op;
    logic        out_illegal;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        logic        ill;
    } exp_t;

    exp_t sb[$];
    int   checks_total  = 0;
    int   checks_passed = 0;

    alu_issue_stage #(.WIDTH(32), .IMM_WIDTH(16), .IDX_W(5)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_aluop(in_aluop), .in_funct(in_funct), .in_use_imm(in_use_imm), .in_imm(in_imm),
        .in_rs_idx(in_rs_idx), .in_rt_idx(in_rt_idx), .in_rs_val(in_rs_val), .in_rt_val(in_rt_val),
        .fwd_valid(fwd_valid), .fwd_idx(fwd_idx), .fwd_data(fwd_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_a(out_a), .out_b(out_b), .out_op(out_op), .out_illegal(out_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks_total++;
        if (act === exp)
            checks_passed++;
        else
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_inputs(input logic [1:0] aluop, input logic [5:0] funct, input logic use_imm,
                              input logic [15:0] imm, input logic [4:0] rs_idx, input logic [4:0] rt_idx,
                              input logic [31:0] rs_val, input logic [31:0] rt_val);
        in_aluop   = aluop;
        in_funct   = funct;
        in_use_imm = use_imm;
        in_imm     = imm;
        in_rs_idx  = rs_idx;
        in_rt_idx  = rt_idx;
        in_rs_val  = rs_val;
        in_rt_val  = rt_val;
        in_valid   = 1'b1;
    endtask

    // Present one instruction for one cycle; if it is expected to be accepted, queue its result
    task automatic apply_stimulus(input string name, input logic [1:0] aluop, input logic [5:0] funct,
                                  input logic use_imm, input logic [15:0] imm,
                                  input logic [4:0] rs_idx, input logic [4:0] rt_idx,
                                  input logic [31:0] rs_val, input logic [31:0] rt_val,
                                  input logic exp_ready, input logic [31:0] ea, input logic [31:0] eb,
                                  input logic [2:0] eop, input logic eill);
        exp_t e;
        set_inputs(aluop, funct, use_imm, imm, rs_idx, rt_idx, rs_val, rt_val);
        check_output({name, "_in_ready"}, {31'b0, in_ready}, {31'b0, exp_ready});
        if (exp_ready) begin
            e.a = ea; e.b = eb; e.op = eop; e.ill = eill;
            sb.push_back(e);
        end
        tick();
        in_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!reset && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks_total++;
                $display("[TB] FAIL unexpected_output: got a=0x%08h op=%0b with no pending entry", out_a, out_op);
            end else begin
                e = sb.pop_front();
                check_output("sb_a", out_a, e.a);
                check_output("sb_b", out_b, e.b);
                check_output("sb_op", {29'b0, out_op}, {29'b0, e.op});
                check_output("sb_illegal", {31'b0, out_illegal}, {31'b0, e.ill});
            end
        end
    end

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_aluop = 2'b00; in_funct = 6'b0; in_use_imm = 1'b0; in_imm = 16'h0;
        in_rs_idx = 5'd0; in_rt_idx = 5'd0; in_rs_val = 32'h0; in_rt_val = 32'h0;
        fwd_valid = 1'b0; fwd_idx = 5'd0; fwd_data = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check_output("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check_output("rst_in_ready", {31'b0, in_ready}, 32'd1);
        check_output("rst_out_a", out_a, 32'h0);
        check_output("rst_out_b", out_b, 32'h0);
        check_output("rst_out_op", {29'b0, out_op}, 32'd2);
        check_output("rst_out_illegal", {31'b0, out_illegal}, 32'd0);
        reset = 1'b0;
        tick();

        $display("[TB] decode vectors");
        out_ready = 1'b1;
        apply_stimulus("or", 2'b10, 6'b100101, 1'b0, 16'h0, 5'd1, 5'd2, 32'h0F0, 32'h00F, 1'b1, 32'h0F0, 32'h00F, 3'b001, 1'b0);
        check_output("or_out_valid", {31'b0, out_valid}, 32'd1);
        apply_stimulus("lw", 2'b00, 6'b0, 1'b1, 16'hFFFC, 5'd1, 5'd2, 32'h100, 32'h7, 1'b1, 32'h100, 32'hFFFFFFFC, 3'b010, 1'b0);
        apply_stimulus("beq", 2'b01, 6'b0, 1'b0, 16'h0, 5'd1, 5'd2, 32'h5, 32'h3, 1'b1, 32'h5, 32'h3, 3'b110, 1'b0);
        apply_stimulus("addi_pos", 2'b00, 6'b0, 1'b1, 16'h7FFF, 5'd1, 5'd2, 32'h1, 32'h9, 1'b1, 32'h1, 32'h00007FFF, 3'b010, 1'b0);
        apply_stimulus("slt", 2'b10, 6'b101010, 1'b0, 16'h0, 5'd1, 5'd2, 32'h8, 32'h9, 1'b1, 32'h8, 32'h9, 3'b111, 1'b0);
        apply_stimulus("and", 2'b10, 6'b100100, 1'b0, 16'h0, 5'd1, 5'd2, 32'hFF, 32'h0F, 1'b1, 32'hFF, 32'h0F, 3'b000, 1'b0);
        apply_stimulus("bad_funct", 2'b10, 6'b000000, 1'b0, 16'h0, 5'd1, 5'd2, 32'hA, 32'hB, 1'b1, 32'hA, 32'hB, 3'b010, 1'b1);
        apply_stimulus("aluop11", 2'b11, 6'b100000, 1'b0, 16'h0, 5'd1, 5'd2, 32'hC, 32'hD, 1'b1, 32'hC, 32'hD, 3'b010, 1'b1);
        tick();

        $display("[TB] back-pressure and skid");
        out_ready = 1'b0;
        apply_stimulus("A", 2'b10, 6'b100000, 1'b0, 16'h0, 5'd1, 5'd2, 32'h11, 32'h22, 1'b1, 32'h11, 32'h22, 3'b010, 1'b0);
        apply_stimulus("B", 2'b10, 6'b100010, 1'b0, 16'h0, 5'd1, 5'd2, 32'h33, 32'h44, 1'b1, 32'h33, 32'h44, 3'b110, 1'b0);
        apply_stimulus("C_blocked", 2'b10, 6'b100100, 1'b0, 16'h0, 5'd1, 5'd2, 32'hF0F0, 32'h0FF0, 1'b0, 32'h0, 32'h0, 3'b000, 1'b0);
        check_output("held_in_ready", {31'b0, in_ready}, 32'd0);
        for (int i = 0; i < 2; i++) begin
            check_output("held_out_valid", {31'b0, out_valid}, 32'd1);
            check_output("held_a", out_a, 32'h11);
            check_output("held_b", out_b, 32'h22);
            check_output("held_op", {29'b0, out_op}, 32'd2);
            tick();
        end
        out_ready = 1'b1;
        set_inputs(2'b10, 6'b100100, 1'b0, 16'h0, 5'd1, 5'd2, 32'hF0F0, 32'h0FF0);
        check_output("C_wait_in_ready", {31'b0, in_ready}, 32'd0);
        tick();
        apply_stimulus("C", 2'b10, 6'b100100, 1'b0, 16'h0, 5'd1, 5'd2, 32'hF0F0, 32'h0FF0, 1'b1, 32'hF0F0, 32'h0FF0, 3'b000, 1'b0);
        repeat (3) tick();
        check_output("skid_drained", sb.size(), 32'd0);

        $display("[TB] flush");
        out_ready = 1'b0;
        apply_stimulus("D", 2'b00, 6'b0, 1'b0, 16'h0, 5'd1, 5'd2, 32'hD0, 32'hD1, 1'b1, 32'hD0, 32'hD1, 3'b010, 1'b0);
        apply_stimulus("E", 2'b01, 6'b0, 1'b0, 16'h0, 5'd1, 5'd2, 32'hE0, 32'hE1, 1'b1, 32'hE0, 32'hE1, 3'b110, 1'b0);
        set_inputs(2'b00, 6'b0, 1'b0, 16'h0, 5'd1, 5'd2, 32'hF0, 32'hF1);
        flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        sb.delete();
        check_output("flush2_out_valid", {31'b0, out_valid}, 32'd0);
        check_output("flush2_in_ready", {31'b0, in_ready}, 32'd1);
        apply_stimulus("G", 2'b00, 6'b0, 1'b0, 16'h0, 5'd1, 5'd2, 32'h60, 32'h61, 1'b1, 32'h60, 32'h61, 3'b010, 1'b0);
        set_inputs(2'b00, 6'b0, 1'b0, 16'h0, 5'd1, 5'd2, 32'h70, 32'h71);
        flush = 1'b1;
        check_output("H_in_ready", {31'b0, in_ready}, 32'd1);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        sb.delete();
        check_output("flush1_out_valid", {31'b0, out_valid}, 32'd0);
        check_output("flush1_in_ready", {31'b0, in_ready}, 32'd1);
        out_ready = 1'b1;
        repeat (3) tick();

        $display("[TB] async reset");
        out_ready = 1'b0;
        apply_stimulus("I", 2'b10, 6'b101010, 1'b0, 16'h0, 5'd1, 5'd2, 32'h99, 32'h98, 1'b1, 32'h99, 32'h98, 3'b111, 1'b0);
        apply_stimulus("J", 2'b00, 6'b0, 1'b1, 16'h8000, 5'd1, 5'd2, 32'h5, 32'h0, 1'b1, 32'h5, 32'hFFFF8000, 3'b010, 1'b0);
        #2 reset = 1'b1;
        #1;
        check_output("arst_out_valid", {31'b0, out_valid}, 32'd0);
        check_output("arst_in_ready", {31'b0, in_ready}, 32'd1);
        check_output("arst_out_a", out_a, 32'h0);
        check_output("arst_out_op", {29'b0, out_op}, 32'd2);
        sb.delete();
        #2 reset = 1'b0;
        tick();

        $display("[TB] forwarding");
        out_ready = 1'b1;
        fwd_valid = 1'b1; fwd_idx = 5'd3; fwd_data = 32'hDEAD;
`ifdef ALU_ISSUE_FWD_EN
        apply_stimulus("fwd_rs", 2'b00, 6'b0, 1'b1, 16'h0, 5'd3, 5'd2, 32'h1, 32'h2, 1'b1, 32'hDEAD, 32'h0, 3'b010, 1'b0);
`else
        apply_stimulus("fwd_rs", 2'b00, 6'b0, 1'b1, 16'h0, 5'd3, 5'd2, 32'h1, 32'h2, 1'b1, 32'h1, 32'h0, 3'b010, 1'b0);
`endif
        fwd_idx = 5'd0;
        apply_stimulus("fwd_zero", 2'b00, 6'b0, 1'b1, 16'h0, 5'd0, 5'd2, 32'h1, 32'h2, 1'b1, 32'h1, 32'h0, 3'b010, 1'b0);
        fwd_idx = 5'd4; fwd_data = 32'h55;
`ifdef ALU_ISSUE_FWD_EN
        apply_stimulus("fwd_rt", 2'b10, 6'b100000, 1'b0, 16'h0, 5'd2, 5'd4, 32'h3, 32'h7, 1'b1, 32'h3, 32'h55, 3'b010, 1'b0);
`else
        apply_stimulus("fwd_rt", 2'b10, 6'b100000, 1'b0, 16'h0, 5'd2, 5'd4, 32'h3, 32'h7, 1'b1, 32'h3, 32'h7, 3'b010, 1'b0);
`endif
        apply_stimulus("fwd_rt_imm", 2'b00, 6'b0, 1'b1, 16'h0010, 5'd2, 5'd4, 32'h3, 32'h7, 1'b1, 32'h3, 32'h10, 3'b010, 1'b0);
        fwd_valid = 1'b0;
        repeat (3) tick();

        check_output("final_sb_empty", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
